// File: rtl/skein_report_pkg.sv
// Shared constants and types for the best-result UART reporter.
package skein_report_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int PKT_BYTES = 36;
    localparam int BITS_PER_FRAME = 10;
    localparam int IDX_W = 6;

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t LAST_IDX = idx_t'(PKT_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser; a new start is taken in the done cycle
// so consecutive frames run with no gap.
module uart_tx_byte
    import skein_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       done_o,
    output logic       ready_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] BIT_LAST = 4'(BITS_PER_FRAME - 1);

    logic [CW-1:0] clk_cnt;
    logic [3:0] bit_cnt;
    logic [BITS_PER_FRAME-1:0] shreg;
    logic active;
    logic bit_end;

    assign bit_end = active && (clk_cnt == CLK_LAST);
    assign done_o = bit_end && (bit_cnt == BIT_LAST);
    assign ready_o = !active || done_o;
    // Idle line is high because the shift register resets to ones.
    assign tx_o = shreg[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active <= 1'b0;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg <= '1;
        end else if (start_i && ready_o) begin
            active <= 1'b1;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg <= {1'b1, data_i, 1'b0};
        end else if (done_o) begin
            active <= 1'b0;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg <= '1;
        end else if (bit_end) begin
            clk_cnt <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            shreg <= {1'b1, shreg[BITS_PER_FRAME-1:1]};
        end else if (active) begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/best_report_tx.sv
// Reports each new best (nonce, bits-off) from the search core
// as a 36-byte checksummed packet over an 8N1 UART line.
module best_report_tx
    import skein_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter logic [9:0] INIT_BITS_OFF = 10'h3FF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [255:0] best_nonce_i,
    input  logic [9:0]   best_bits_off_i,
    input  logic         enable_i,
    input  logic         force_report_i,
    output logic         tx_o,
    output logic         busy_o,
    output logic         pending_o
);

    state_t state, state_nx;
    idx_t idx, sel;
    logic [9:0] last_q, snap_bits;
    logic [255:0] nonce_sh;
    logic [7:0] csum, data;
    logic pend_q;
    logic changed, req, capture;
    logic start, done, ready, last_byte;

    assign changed = best_bits_off_i != last_q;
    assign req = enable_i && (changed || force_report_i || pend_q);
    assign capture = (state == IDLE) && req;
    assign last_byte = idx == LAST_IDX;
    assign start = (state == SEND) && ready && !(done && last_byte);
    // The byte launched in a done cycle is the following one.
    assign sel = done ? idx + idx_t'(1) : idx;

    assign busy_o = state == SEND;
    assign pending_o = pend_q;

    always_comb begin
        data = nonce_sh[255:248];
        unique case (sel)
            6'd0: data = SYNC_BYTE;
            6'd1: data = {6'b0, snap_bits[9:8]};
            6'd2: data = snap_bits[7:0];
            LAST_IDX: data = csum;
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (req) state_nx = SEND;
            SEND: if (done && last_byte) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= INIT_BITS_OFF;
            snap_bits <= '0;
            nonce_sh <= '0;
            csum <= '0;
            idx <= '0;
            pend_q <= 1'b0;
        end else if (capture) begin
            last_q <= best_bits_off_i;
            snap_bits <= best_bits_off_i;
            nonce_sh <= best_nonce_i;
            csum <= '0;
            idx <= '0;
            pend_q <= 1'b0;
        end else begin
            if (state != IDLE && (changed || force_report_i)) begin
                pend_q <= 1'b1;
            end
            if (done && !last_byte) begin
                idx <= idx + idx_t'(1);
            end
            if (start && sel != 6'd0 && sel != LAST_IDX) begin
                csum <= csum ^ data;
            end
            // Nonce bytes leave MSB first; shift the private copy.
            if (start && sel >= 6'd3 && sel != LAST_IDX) begin
                nonce_sh <= {nonce_sh[247:0], 8'h00};
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(start),
        .data_i (data),
        .tx_o   (tx_o),
        .done_o (done),
        .ready_o(ready)
    );

endmodule

// File: tb/tb_best_report_tx.sv
// Randomised scoreboard bench for best_report_tx: a reference model
// queues expected packets, a UART monitor decodes and compares them.
module tb_best_report_tx;

    localparam int CPB = 4;
    localparam int PKT_CYC = 360 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic force_r = 1'b0;
    logic [255:0] nonce = '0;
    logic [9:0] bits = 10'h3FF;
    logic tx, busy, pending;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [9:0] m_last = 10'h3FF;
    logic m_pend = 1'b0;
    int m_cap = -100000;
    logic [7:0] exp_bytes[$];
    int exp_cap[$];

    int in_frame = 0;
    int fstart = 0;
    int byte_j = 0;
    int pcap = 0;
    int run = 0;
    logic [7:0] sh;

    best_report_tx #(
        .CLKS_PER_BIT(CPB),
        .INIT_BITS_OFF(10'h3FF)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .best_nonce_i   (nonce),
        .best_bits_off_i(bits),
        .enable_i       (enable),
        .force_report_i (force_r),
        .tx_o           (tx),
        .busy_o         (busy),
        .pending_o      (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic void push_packet(input logic [9:0] b,
                                        input logic [255:0] n,
                                        input int e);
        logic [7:0] cs;
        logic [255:0] nn;
        logic [7:0] x;
        nn = n;
        exp_cap.push_back(e);
        exp_bytes.push_back(8'hA5);
        x = {6'b0, b[9:8]};
        exp_bytes.push_back(x);
        cs = x;
        exp_bytes.push_back(b[7:0]);
        cs = cs ^ b[7:0];
        for (int i = 0; i < 32; i++) begin
            x = nn[255:248];
            nn = nn << 8;
            exp_bytes.push_back(x);
            cs = cs ^ x;
        end
        exp_bytes.push_back(cs);
    endfunction

    function automatic logic model_idle();
        return cyc >= m_cap + PKT_CYC + 3;
    endfunction

    // Reference model: a report occupies PKT_CYC+1 busy cycles plus
    // a done and an idle cycle before the next capture can happen.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_last = 10'h3FF;
            m_pend = 1'b0;
            m_cap = -100000;
            exp_bytes.delete();
            exp_cap.delete();
        end else if (model_idle()) begin
            if (enable && (bits != m_last || force_r || m_pend)) begin
                push_packet(bits, nonce, cyc);
                m_last = bits;
                m_pend = 1'b0;
                m_cap = cyc;
            end
        end else if (force_r || bits != m_last) begin
            m_pend = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 0;
            byte_j = 0;
            run = 0;
        end else begin
            check("busy", 32'(busy),
                  32'(cyc >= m_cap && cyc <= m_cap + PKT_CYC));
            check("pending", 32'(pending), 32'(m_pend));
            if (busy) begin
                run++;
            end else if (run > 0) begin
                check("busy_len", run, PKT_CYC + 1);
                run = 0;
            end
            if (in_frame == 0 && tx === 1'b0) begin
                in_frame = 1;
                fstart = cyc;
                if (byte_j == 0) begin
                    n_cmp++;
                    if (exp_cap.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_pkt @cyc %0d: got start bit, expected idle line",
                                 cyc);
                        pcap = cyc - 1;
                    end else begin
                        pcap = exp_cap.pop_front();
                    end
                end
                check("byte_start", cyc, pcap + 1 + 10 * CPB * byte_j);
            end
            if (in_frame != 0 && (cyc - fstart) % CPB == CPB / 2) begin
                if ((cyc - fstart) / CPB == 0) begin
                    check("start_bit", 32'(tx), 0);
                end else if ((cyc - fstart) / CPB <= 8) begin
                    sh = {tx, sh[7:1]};
                end else begin
                    check("stop_bit", 32'(tx), 1);
                    if (exp_bytes.size() == 0) begin
                        check("byte_queued", 0, 1);
                    end else begin
                        check($sformatf("byte%0d", byte_j), 32'(sh),
                              32'(exp_bytes.pop_front()));
                    end
                    in_frame = 0;
                    byte_j = (byte_j + 1) % 36;
                end
            end
        end
    end

    task automatic pulse_force();
        @(negedge clk);
        force_r = 1'b1;
        @(negedge clk);
        force_r = 1'b0;
    endtask

    task automatic wait_busy(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        check("busy_rise", 32'(busy), 1);
    endtask

    task automatic wait_quiet(input int limit);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (model_idle() && !m_pend) begin
                ok = 1'b1;
                break;
            end
        end
        check("quiet", 32'(ok), 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        bits = 10'h3FF;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 1);
        check("reset_busy", 32'(busy), 0);
        rst = 1'b0;

        repeat (2000) @(negedge clk);
        check("idle_tx", 32'(tx), 1);

        for (int i = 0; i < 32; i++) begin
            nonce = {nonce[247:0], 8'(i + 1)};
        end
        bits = 10'h19A;
        wait_busy(10);
        repeat (300) @(negedge clk);
        bits = 10'h0F0;
        @(negedge clk);
        check("pending_set", 32'(pending), 1);
        repeat (300) @(negedge clk);
        bits = 10'h0A0;
        wait_quiet(5000);

        pulse_force();
        wait_quiet(3000);
        enable = 1'b0;
        pulse_force();
        repeat (50) @(negedge clk);
        enable = 1'b1;
        repeat (50) @(negedge clk);
        check("force_dropped", 32'(busy), 0);

        nonce = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
        bits = 10'h155;
        wait_busy(10);
        repeat (413) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_tx", 32'(tx), 1);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_pend", 32'(pending), 0);
        bits = 10'h3FF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);

        bits = 10'h2C3;
        wait_busy(10);
        repeat (800) @(negedge clk);
        enable = 1'b0;
        bits = 10'h111;
        repeat (900) @(negedge clk);
        check("held_pending", 32'(pending), 1);
        check("held_busy", 32'(busy), 0);
        enable = 1'b1;
        wait_quiet(3000);

        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            force_r = ($urandom % 400) == 0;
            if ($urandom % 350 == 0) begin
                bits = 10'($urandom);
                nonce = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
            end
            if ($urandom % 900 == 0) enable = ~enable;
        end
        force_r = 1'b0;
        enable = 1'b1;
        wait_quiet(6000);
        check("drain_bytes", exp_bytes.size(), 0);
        check("drain_pkts", exp_cap.size(), 0);
        check("drain_frame", byte_j, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
